// File: rtl/relay_scheduler.sv
// rtl/relay_scheduler.sv - round-robin sequencer for relays sharing one driver supply
// At most one relay is on; each grant is a fixed on-time followed by an all-off guard gap.
module relay_scheduler #(
   parameter int N_CH            = 4,
   parameter int CLK_FREQ        = 50000000,
   parameter int ACTIVE_TIME_SEC = 5,
   parameter int GAP_CYCLES      = 5000000,
   localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] req,
   input  logic [N_CH-1:0] ch_en,
   input  logic            abort,
   output logic [N_CH-1:0] relay_out,
   output logic            busy,
   output logic [CH_W-1:0] active_ch,
   output logic [N_CH-1:0] pending,
   output logic            done
);

   localparam longint ACTIVE_CYCLES = longint'(CLK_FREQ) * longint'(ACTIVE_TIME_SEC);
   localparam logic [31:0] ACT_LAST = 32'(ACTIVE_CYCLES - 1);
   localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

   state_t          state_q;
   logic [N_CH-1:0] relay_q;
   logic [CH_W-1:0] active_q;
   logic [N_CH-1:0] pending_q;
   logic            done_q;
   logic [N_CH-1:0] req_prev_q;
   logic [CH_W-1:0] ptr_q;
   logic [31:0]     cnt_q;

   logic [N_CH-1:0] req_edge;
   logic [N_CH-1:0] avail;
   logic [N_CH-1:0] set_mask;
   logic [N_CH-1:0] active_oh;
   logic [N_CH-1:0] grant_oh;
   logic [CH_W-1:0] grant_idx;
   logic [CH_W-1:0] ptr_d;
   logic            grant_vld;
   logic            do_grant;
   logic            retrig;

   // First set bit at or after ptr, wrapping; MSB of the result flags a hit.
   function automatic logic [CH_W:0] pick(input logic [N_CH-1:0] p, input logic [CH_W-1:0] ptr);
      logic [CH_W:0] r;
      int            idx;
      r = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N_CH;
         if (p[CH_W'(idx)]) r = {1'b1, CH_W'(idx)};
      end
      return r;
   endfunction

   always_comb begin
      req_edge  = req & ~req_prev_q;
      avail     = pending_q & ch_en;
      {grant_vld, grant_idx} = pick(avail, ptr_q);
      grant_oh  = '0;
      if (grant_vld) grant_oh[grant_idx] = 1'b1;
      active_oh = '0;
      active_oh[active_q] = 1'b1;
      retrig    = (state_q == S_ON) && req_edge[active_q];
      // An edge on the channel being driven extends it instead of queueing it.
      set_mask  = req_edge & ch_en & ((state_q == S_ON) ? ~active_oh : {N_CH{1'b1}});
      do_grant  = grant_vld &&
                  ((state_q == S_IDLE) || ((state_q == S_GAP) && (cnt_q == GAP_LAST)));
      ptr_d     = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         relay_q    <= '0;
         active_q   <= '0;
         pending_q  <= '0;
         done_q     <= 1'b0;
         req_prev_q <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
      end else begin
         req_prev_q <= req;
         done_q     <= 1'b0;
         if (abort) begin
            relay_q   <= '0;
            pending_q <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
         end else begin
            pending_q <= avail | set_mask;
            case (state_q)
               S_IDLE: ;
               S_ON: begin
                  if (!ch_en[active_q]) begin
                     relay_q <= '0;
                     state_q <= S_GAP;
                     cnt_q   <= '0;
                  end else if (retrig) begin
                     cnt_q <= '0;
                  end else if (cnt_q == ACT_LAST) begin
                     relay_q <= '0;
                     done_q  <= 1'b1;
                     state_q <= S_GAP;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 32'd1;
                  end
               end
               S_GAP: begin
                  if (cnt_q == GAP_LAST) state_q <= S_IDLE;
                  else                   cnt_q   <= cnt_q + 32'd1;
               end
               default: state_q <= S_IDLE;
            endcase
            // A same-edge request on the granted channel survives in pending.
            if (do_grant) begin
               state_q   <= S_ON;
               relay_q   <= grant_oh;
               active_q  <= grant_idx;
               ptr_q     <= ptr_d;
               cnt_q     <= '0;
               pending_q <= (avail & ~grant_oh) | set_mask;
            end
         end
      end
   end

   assign relay_out = relay_q;
   assign busy      = (state_q != S_IDLE);
   assign active_ch = active_q;
   assign pending   = pending_q;
   assign done      = done_q;

endmodule

// File: tb/tb_relay_scheduler.sv
// tb/tb_relay_scheduler.sv - directed and randomized bench for relay_scheduler
module tb_relay_scheduler;

   localparam int N  = 4;
   localparam int AC = 10;
   localparam int GC = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] ch_en = 4'b1111;
   logic       abort = 1'b0;
   logic [3:0] relay_out;
   logic       busy;
   logic [1:0] active_ch;
   logic [3:0] pending;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   relay_scheduler #(
      .N_CH(N), .CLK_FREQ(10), .ACTIVE_TIME_SEC(1), .GAP_CYCLES(GC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ch_en(ch_en), .abort(abort),
      .relay_out(relay_out), .busy(busy), .active_ch(active_ch),
      .pending(pending), .done(done)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0=idle 1=on 2=gap, m_left = cycles remaining in the phase.
   logic [3:0] m_relay, m_pend, m_prev, m_e, m_avail, m_sets;
   logic       m_done;
   int         m_act, m_ptr, m_phase, m_left, m_c;
   bit         m_go, m_found;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_relay = 0; m_pend = 0; m_prev = 0; m_done = 0;
         m_act = 0; m_ptr = 0; m_phase = 0; m_left = 0;
      end else begin
         m_e = req & ~m_prev;
         m_prev = req;
         m_done = 0;
         if (abort) begin
            m_relay = 0; m_pend = 0; m_phase = 0;
         end else begin
            m_avail = m_pend & ch_en;
            m_sets  = m_e & ch_en;
            m_go    = 0;
            if (m_phase == 1) begin
               m_sets[m_act] = 1'b0;
               if (!ch_en[m_act]) begin
                  m_relay = 0; m_phase = 2; m_left = GC;
               end else if (m_e[m_act]) begin
                  m_left = AC;
               end else if (m_left == 1) begin
                  m_relay = 0; m_done = 1; m_phase = 2; m_left = GC;
               end else begin
                  m_left--;
               end
            end else if (m_phase == 2) begin
               if (m_left == 1) begin m_phase = 0; m_go = 1; end
               else m_left--;
            end else begin
               m_go = 1;
            end
            if (m_go && m_avail != 0) begin
               m_found = 0;
               for (int k = 0; k < N; k++) begin
                  if (!m_found && m_avail[(m_ptr + k) % N]) begin
                     m_found = 1;
                     m_c = (m_ptr + k) % N;
                  end
               end
               m_avail[m_c] = 1'b0;
               m_act = m_c;
               m_relay = 4'(1 << m_c);
               m_phase = 1;
               m_left = AC;
               m_ptr = (m_c + 1) % N;
            end
            m_pend = m_avail | m_sets;
         end
      end
   end

   function automatic int oh2i(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; req = 0; abort = 0; ch_en = 4'b1111;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic pulse_req(input logic [3:0] v);
      req = v;
      @(negedge clk);
      req = 0;
   endtask

   int ord[$], ons[$], gaps[$];

   task automatic observe(input int ncyc);
      logic [3:0] prv;
      int run;
      prv = relay_out; run = 0;
      ord.delete(); ons.delete(); gaps.delete();
      repeat (ncyc) begin
         @(negedge clk);
         if (relay_out != prv) begin
            if (prv != 0) ons.push_back(run);
            else if (ord.size() > 0) gaps.push_back(run);
            if (relay_out != 0) ord.push_back(oh2i(relay_out));
            run = 1;
         end else run++;
         prv = relay_out;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_checks++;
      if ({relay_out, busy, active_ch, pending, done} !== 12'h0) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=000", {relay_out, busy, active_ch, pending, done});
      end
   endtask

   task automatic test_single();
      int hi, bz, dn;
      do_reset();
      req = 4'b0100;
      @(negedge clk);
      req = 0;
      n_checks++;
      if (pending !== 4'b0100 || relay_out !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_pending got=%b/%b exp=0100/0000", pending, relay_out);
      end
      hi = 0; bz = 0; dn = 0;
      repeat (25) begin
         @(negedge clk);
         if (relay_out == 4'b0100) hi++;
         if (busy) bz++;
         if (done) dn++;
      end
      n_checks++;
      if (hi != AC || bz != AC + GC || dn != 1 || pending !== 0) begin
         n_fail++;
         $display("FAIL single_timing on=%0d busy=%0d done=%0d exp=%0d/%0d/1", hi, bz, dn, AC, AC + GC);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      pulse_req(4'b1011);
      observe(50);
      n_checks++;
      if (ord.size() != 3 || ord[0] != 0 || ord[1] != 1 || ord[2] != 3) begin
         n_fail++;
         $display("FAIL rr_order got=%p exp=0,1,3", ord);
      end
      n_checks++;
      if (ons.size() != 3 || gaps.size() != 2 || ons.sum() != 3 * AC || gaps.sum() != 2 * GC) begin
         n_fail++;
         $display("FAIL rr_lengths ons=%p gaps=%p exp 10s and 3s", ons, gaps);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_idle busy=%b exp=0", busy);
      end
      pulse_req(4'b0011);
      observe(35);
      n_checks++;
      if (ord.size() != 2 || ord[0] != 0 || ord[1] != 1 || gaps.size() != 1 || gaps[0] != GC) begin
         n_fail++;
         $display("FAIL rr_wrap order=%p gaps=%p exp=0,1 gap 3", ord, gaps);
      end
   endtask

   task automatic test_retrigger();
      int hi, dn, t;
      bit pulsed;
      do_reset();
      pulse_req(4'b0010);
      t = 0;
      while (!relay_out[1] && t < 10) begin @(negedge clk); t++; end
      hi = relay_out[1] ? 1 : 0;
      dn = 0; pulsed = 0;
      repeat (30) begin
         @(negedge clk);
         req = 0;
         if (relay_out[1]) hi++;
         if (done) dn++;
         if (hi == 6 && !pulsed) begin req = 4'b0010; pulsed = 1; end
      end
      n_checks++;
      if (hi != 16 || dn != 1 || pending !== 0) begin
         n_fail++;
         $display("FAIL retrigger on=%0d done=%0d pend=%b exp=16/1/0000", hi, dn, pending);
      end
   endtask

   task automatic test_abort();
      int bad;
      do_reset();
      pulse_req(4'b0001);
      @(negedge clk);
      pulse_req(4'b1010);
      n_checks++;
      if (pending !== 4'b1010 || relay_out !== 4'b0001) begin
         n_fail++;
         $display("FAIL abort_setup pend=%b relay=%b exp=1010/0001", pending, relay_out);
      end
      abort = 1;
      @(negedge clk);
      abort = 0;
      n_checks++;
      if ({relay_out, pending, busy, done} !== 10'h0) begin
         n_fail++;
         $display("FAIL abort_clear relay=%b pend=%b busy=%b done=%b exp all 0", relay_out, pending, busy, done);
      end
      bad = 0;
      repeat (25) begin
         @(negedge clk);
         if (relay_out != 0 || busy || done) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL abort_quiet active_cycles=%0d exp=0", bad);
      end
   endtask

   task automatic test_enable();
      int bz, dn;
      do_reset();
      ch_en = 4'b1011;
      pulse_req(4'b0100);
      n_checks++;
      if (pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL en_mask pend=%b exp=0000", pending);
      end
      ch_en = 4'b1111;
      pulse_req(4'b0001);
      repeat (4) @(negedge clk);
      ch_en = 4'b1110;
      @(negedge clk);
      n_checks++;
      if (relay_out !== 4'b0000 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL en_drop relay=%b busy=%b exp=0000/1", relay_out, busy);
      end
      bz = 1; dn = done ? 1 : 0;
      repeat (10) begin
         @(negedge clk);
         if (busy) bz++;
         if (done) dn++;
      end
      ch_en = 4'b1111;
      n_checks++;
      if (bz != GC || dn != 0) begin
         n_fail++;
         $display("FAIL en_gap busy=%0d done=%0d exp=%0d/0", bz, dn, GC);
      end
   endtask

   task automatic test_async_reset();
      int t, bad;
      do_reset();
      pulse_req(4'b1000);
      @(negedge clk);
      pulse_req(4'b0010);
      t = 0;
      while (!done && t < 20) begin @(negedge clk); t++; end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || relay_out !== 0 || pending !== 4'b0010 || active_ch !== 2'd3) begin
         n_fail++;
         $display("FAIL ar_setup busy=%b relay=%b pend=%b act=%0d exp=1/0000/0010/3", busy, relay_out, pending, active_ch);
      end
      #2 rst_n = 0;
      #1;
      n_checks++;
      if ({relay_out, busy, active_ch, pending, done} !== 12'h0) begin
         n_fail++;
         $display("FAIL ar_immediate got=%h exp=000", {relay_out, busy, active_ch, pending, done});
      end
      @(negedge clk);
      rst_n = 1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy || relay_out != 0 || pending != 0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL ar_stays_idle active_cycles=%0d exp=0", bad);
      end
   endtask

   task automatic test_random();
      int bad, ohbad, r;
      do_reset();
      bad = 0; ohbad = 0;
      repeat (2000) begin
         @(negedge clk);
         n_checks++;
         if ({relay_out, busy, active_ch, pending, done} !==
             {m_relay, m_phase != 0, 2'(m_act), m_pend, m_done}) begin
            n_fail++;
            bad++;
            if (bad < 10)
               $display("FAIL rand_model t=%0t got r=%b b=%b a=%0d p=%b d=%b exp r=%b b=%b a=%0d p=%b d=%b",
                        $time, relay_out, busy, active_ch, pending, done,
                        m_relay, m_phase != 0, m_act, m_pend, m_done);
         end
         if ($countones(relay_out) > 1) ohbad++;
         req   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
         r     = $urandom_range(0, 99);
         ch_en = (r < 3) ? ~(4'b1 << $urandom_range(0, 3)) : 4'b1111;
         abort = ($urandom_range(0, 199) == 0);
      end
      req = 0; abort = 0; ch_en = 4'b1111;
      n_checks++;
      if (ohbad != 0) begin
         n_fail++;
         $display("FAIL onehot_invariant violations=%0d exp=0", ohbad);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_retrigger();
      test_abort();
      test_enable();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
